// File: rtl/ram_responder_if.sv
// Memory handshake bundle between the control unit (master) and the RAM responder (slave).
// Carries the MOV/MOC handshake, the access attributes, and both data paths.
interface ram_responder_if #(
    parameter int ADDR_W = 8
);
    logic              MOV;
    logic              RW;
    logic              typeData;
    logic [ADDR_W-1:0] Address;
    logic [31:0]       DataIn;
    logic [31:0]       DataOut;
    logic              MOC;

    modport master (
        output MOV, RW, typeData, Address, DataIn,
        input  DataOut, MOC
    );

    modport slave (
        input  MOV, RW, typeData, Address, DataIn,
        output DataOut, MOC
    );
endinterface

// File: rtl/ram_responder.sv
// Memory-side responder: accepts a MOV request, waits WAIT_STATES cycles, then performs a
// big-endian byte/word access on an internal RAM and holds MOC until MOV drops.
module ram_responder #(
    parameter int ADDR_W      = 8,
    parameter int WAIT_STATES = 2
) (
    input  logic             CLK,
    input  logic             CLR,
    ram_responder_if.slave   bus
);
    localparam int         DEPTH     = 1 << ADDR_W;
    localparam logic [3:0] WAIT_INIT = 4'(WAIT_STATES);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              rw_q, rw_d;
    logic              word_q, word_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [31:0]       dout_q, dout_d;
    logic              moc_q, moc_d;
    logic              memWe;

    logic [7:0]        mem [DEPTH];

    // Word lanes come from the aligned base, so a word never wraps past the top of memory.
    logic [ADDR_W-1:0] base, addr1, addr2, addr3;
    logic [31:0]       rdData;

    always_comb begin
        base   = {addr_q[ADDR_W-1:2], 2'd0};
        addr1  = {addr_q[ADDR_W-1:2], 2'd1};
        addr2  = {addr_q[ADDR_W-1:2], 2'd2};
        addr3  = {addr_q[ADDR_W-1:2], 2'd3};
        rdData = word_q ? {mem[base], mem[addr1], mem[addr2], mem[addr3]}
                        : {24'h0, mem[addr_q]};
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rw_d    = rw_q;
        word_d  = word_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        dout_d  = dout_q;
        moc_d   = moc_q;
        memWe   = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.MOV) begin
                    rw_d    = bus.RW;
                    word_d  = bus.typeData;
                    addr_d  = bus.Address;
                    wdata_d = bus.DataIn;
                    cnt_d   = WAIT_INIT;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    memWe   = ~rw_q;
                    if (rw_q) dout_d = rdData;
                    moc_d   = 1'b1;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (!bus.MOV) begin
                    moc_d   = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge CLR) begin
        if (!CLR) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            rw_q    <= 1'b0;
            word_q  <= 1'b0;
            addr_q  <= '0;
            wdata_q <= 32'h0;
            dout_q  <= 32'h0;
            moc_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rw_q    <= rw_d;
            word_q  <= word_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            dout_q  <= dout_d;
            moc_q   <= moc_d;
        end
    end

    // Storage is not reset; memWe is low while CLR holds the FSM in IDLE, so aborted writes never land.
    always_ff @(posedge CLK) begin
        if (memWe) begin
            if (word_q) begin
                mem[base]  <= wdata_q[31:24];
                mem[addr1] <= wdata_q[23:16];
                mem[addr2] <= wdata_q[15:8];
                mem[addr3] <= wdata_q[7:0];
            end else begin
                mem[addr_q] <= wdata_q[7:0];
            end
        end
    end

    assign bus.DataOut = dout_q;
    assign bus.MOC     = moc_q;
endmodule

// File: tb/tb_ram_responder.sv
// Bench for ram_responder: a slow (2 wait states) and a fast (0 wait states) instance share stimulus
// and are checked against a byte-array memory model and expected-latency arithmetic.
module tb_ram_responder;
    logic        clk = 1'b0;
    logic        clrN;
    logic        mov;
    logic        rw;
    logic        typeData;
    logic [7:0]  addr;
    logic [31:0] dataIn;
    logic        useFast;

    int total = 0;
    int bad   = 0;

    logic [7:0]  refMem  [2][256];
    logic [31:0] refDout [2];

    ram_responder_if #(.ADDR_W(8)) ifSlow ();
    ram_responder_if #(.ADDR_W(8)) ifFast ();

    assign ifSlow.MOV      = mov & ~useFast;
    assign ifSlow.RW       = rw;
    assign ifSlow.typeData = typeData;
    assign ifSlow.Address  = addr;
    assign ifSlow.DataIn   = dataIn;
    assign ifFast.MOV      = mov & useFast;
    assign ifFast.RW       = rw;
    assign ifFast.typeData = typeData;
    assign ifFast.Address  = addr;
    assign ifFast.DataIn   = dataIn;

    wire        moc  = useFast ? ifFast.MOC : ifSlow.MOC;
    wire [31:0] dout = useFast ? ifFast.DataOut : ifSlow.DataOut;

    ram_responder #(.ADDR_W(8), .WAIT_STATES(2)) dutSlow (.CLK(clk), .CLR(clrN), .bus(ifSlow));
    ram_responder #(.ADDR_W(8), .WAIT_STATES(0)) dutFast (.CLK(clk), .CLR(clrN), .bus(ifFast));

    always #5 clk = ~clk;

    function automatic logic [31:0] modelRead(input int s, input logic w, input logic [7:0] a);
        logic [7:0] b;
        b = a & 8'hFC;
        if (w) return {refMem[s][b], refMem[s][b + 8'd1], refMem[s][b + 8'd2], refMem[s][b + 8'd3]};
        return {24'h0, refMem[s][a]};
    endfunction

    task automatic modelWrite(input int s, input logic w, input logic [7:0] a, input logic [31:0] d);
        logic [7:0] b;
        b = a & 8'hFC;
        if (w) begin
            refMem[s][b]        = d[31:24];
            refMem[s][b + 8'd1] = d[23:16];
            refMem[s][b + 8'd2] = d[15:8];
            refMem[s][b + 8'd3] = d[7:0];
        end else begin
            refMem[s][a] = d[7:0];
        end
    endtask

    task automatic startReq(input logic r, input logic w, input logic [7:0] a, input logic [31:0] d);
        @(negedge clk);
        rw = r; typeData = w; addr = a; dataIn = d; mov = 1'b1;
        @(posedge clk); #1;
        rw = 1'($urandom); typeData = 1'($urandom); addr = 8'($urandom); dataIn = $urandom;
    endtask

    task automatic waitMoc(output int edges);
        edges = 0;
        while (moc !== 1'b1 && edges < 40) begin
            @(posedge clk); #1;
            edges++;
        end
    endtask

    // Full transaction with normal release; the model is updated as the access completes.
    task automatic runReq(input logic r, input logic w, input logic [7:0] a, input logic [31:0] d,
                          output int edges, output logic [31:0] seen, output logic mocAfter);
        int s;
        s = useFast ? 1 : 0;
        startReq(r, w, a, d);
        waitMoc(edges);
        seen = dout;
        if (r) refDout[s] = modelRead(s, w, a);
        else   modelWrite(s, w, a, d);
        @(negedge clk); mov = 1'b0;
        @(posedge clk); #1;
        mocAfter = moc;
    endtask

    task automatic initMem;
        int e; logic [31:0] d; logic m;
        for (int s = 0; s < 2; s++) begin
            useFast = (s == 1);
            for (int i = 0; i < 64; i++) runReq(1'b0, 1'b1, 8'(i * 4), $urandom, e, d, m);
        end
        useFast = 1'b0;
    endtask

    task automatic test_reset;
        clrN = 1'b0; mov = 1'b0; rw = 1'b0; typeData = 1'b0; addr = 8'h0; dataIn = 32'h0; useFast = 1'b0;
        refDout[0] = 32'h0; refDout[1] = 32'h0;
        #12;
        total++;
        if (ifSlow.MOC !== 1'b0 || ifFast.MOC !== 1'b0) begin
            bad++; $display("[TB] FAIL reset_moc: got slow=%b fast=%b, want 0", ifSlow.MOC, ifFast.MOC);
        end
        total++;
        if (ifSlow.DataOut !== 32'h0 || ifFast.DataOut !== 32'h0) begin
            bad++; $display("[TB] FAIL reset_dout: got slow=%h fast=%h, want 0", ifSlow.DataOut, ifFast.DataOut);
        end
        @(negedge clk); clrN = 1'b1;
    endtask

    task automatic test_word_write_read;
        int e; logic [31:0] d; logic m;
        useFast = 1'b0;
        runReq(1'b0, 1'b1, 8'h10, 32'hDEADBEEF, e, d, m);
        total++;
        if (e != 3) begin bad++; $display("[TB] FAIL ww_latency: got %0d edges, want 3", e); end
        total++;
        if (m !== 1'b0) begin bad++; $display("[TB] FAIL ww_moc_release: got %b, want 0", m); end
        runReq(1'b1, 1'b0, 8'h10, 32'h0, e, d, m);
        total++;
        if (d !== 32'h000000DE) begin bad++; $display("[TB] FAIL br_10: got %h, want 000000de", d); end
        runReq(1'b1, 1'b0, 8'h13, 32'h0, e, d, m);
        total++;
        if (d !== 32'h000000EF) begin bad++; $display("[TB] FAIL br_13: got %h, want 000000ef", d); end
    endtask

    task automatic test_byte_write_word_read;
        int e; logic [31:0] d, expD; logic m;
        useFast = 1'b0;
        runReq(1'b0, 1'b0, 8'h21, 32'h123456AA, e, d, m);
        expD = modelRead(0, 1'b1, 8'h23);
        runReq(1'b1, 1'b1, 8'h23, 32'h0, e, d, m);
        total++;
        if (d !== expD) begin bad++; $display("[TB] FAIL bw_wr_word: got %h, want %h", d, expD); end
        total++;
        if (d[23:16] !== 8'hAA) begin bad++; $display("[TB] FAIL bw_wr_lane: got %h, want aa", d[23:16]); end
    endtask

    task automatic test_handshake_hold;
        int e; logic [31:0] d, expD; logic m; int holdBad;
        useFast = 1'b0;
        startReq(1'b0, 1'b1, 8'h30, 32'hA5A50001);
        rw = 1'b0; typeData = 1'b1; addr = 8'h30; dataIn = 32'h5A5A0002;
        waitMoc(e);
        total++;
        if (e != 3) begin bad++; $display("[TB] FAIL hold_latency: got %0d edges, want 3", e); end
        holdBad = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            if (moc !== 1'b1) holdBad++;
        end
        total++;
        if (holdBad != 0) begin bad++; $display("[TB] FAIL hold_moc: MOC low on %0d of 10 cycles, want 0", holdBad); end
        @(negedge clk); mov = 1'b0;
        @(posedge clk); #1;
        total++;
        if (moc !== 1'b0) begin bad++; $display("[TB] FAIL hold_release: got %b, want 0", moc); end
        modelWrite(0, 1'b1, 8'h30, 32'hA5A50001);
        expD = modelRead(0, 1'b1, 8'h30);
        runReq(1'b1, 1'b1, 8'h30, 32'h0, e, d, m);
        total++;
        if (d !== expD) begin bad++; $display("[TB] FAIL hold_single_access: got %h, want %h", d, expD); end
    endtask

    task automatic test_early_drop;
        int e; logic [31:0] d; logic m;
        useFast = 1'b0;
        startReq(1'b0, 1'b1, 8'h44, 32'h12345678);
        @(negedge clk); mov = 1'b0;
        waitMoc(e);
        total++;
        if (e != 3) begin bad++; $display("[TB] FAIL drop_latency: got %0d edges, want 3", e); end
        @(posedge clk); #1;
        total++;
        if (moc !== 1'b0) begin bad++; $display("[TB] FAIL drop_pulse: got %b, want 0", moc); end
        modelWrite(0, 1'b1, 8'h44, 32'h12345678);
        runReq(1'b1, 1'b1, 8'h44, 32'h0, e, d, m);
        total++;
        if (d !== 32'h12345678) begin bad++; $display("[TB] FAIL drop_readback: got %h, want 12345678", d); end
    endtask

    task automatic test_mid_reset;
        int e; logic [31:0] d, expD; logic m;
        useFast = 1'b0;
        startReq(1'b1, 1'b0, 8'h10, 32'h0);
        waitMoc(e);
        #2 clrN = 1'b0;
        #1;
        total++;
        if (ifSlow.MOC !== 1'b0 || ifSlow.DataOut !== 32'h0) begin
            bad++; $display("[TB] FAIL midreset_async: got moc=%b dout=%h, want 0/0", ifSlow.MOC, ifSlow.DataOut);
        end
        mov = 1'b0; refDout[0] = 32'h0; refDout[1] = 32'h0;
        @(negedge clk); clrN = 1'b1;
        startReq(1'b0, 1'b1, 8'h40, 32'hCAFEF00D);
        @(posedge clk); #2 clrN = 1'b0;
        #1 mov = 1'b0;
        @(negedge clk); clrN = 1'b1;
        expD = modelRead(0, 1'b1, 8'h40);
        runReq(1'b1, 1'b1, 8'h40, 32'h0, e, d, m);
        total++;
        if (d !== expD) begin bad++; $display("[TB] FAIL abort_no_commit: got %h, want %h", d, expD); end
    endtask

    task automatic test_fast_wrap;
        int e; logic [31:0] d, expD; logic m; logic [8:0] addr9;
        useFast = 1'b1;
        total++;
        if (ifFast.DataOut !== 32'h0) begin bad++; $display("[TB] FAIL fast_reset_dout: got %h, want 0", ifFast.DataOut); end
        expD = modelRead(1, 1'b1, 8'hFE);
        runReq(1'b1, 1'b1, 8'hFE, 32'h0, e, d, m);
        total++;
        if (e != 1) begin bad++; $display("[TB] FAIL fast_latency: got %0d edges, want 1", e); end
        total++;
        if (d !== expD) begin bad++; $display("[TB] FAIL fast_word_fe: got %h, want %h", d, expD); end
        addr9 = 9'h105;
        runReq(1'b0, 1'b0, addr9[7:0], 32'h00000077, e, d, m);
        runReq(1'b1, 1'b0, 8'h05, 32'h0, e, d, m);
        total++;
        if (d !== 32'h00000077) begin bad++; $display("[TB] FAIL wrap_byte_05: got %h, want 00000077", d); end
        runReq(1'b1, 1'b1, 8'h04, 32'h0, e, d, m);
        total++;
        if (d[23:16] !== 8'h77) begin bad++; $display("[TB] FAIL wrap_word_lane: got %h, want 77", d[23:16]); end
        useFast = 1'b0;
    endtask

    task automatic test_random;
        int e, s; logic [31:0] d, expD, wd; logic m, r, w; logic [7:0] a;
        for (int i = 0; i < 40; i++) begin
            s = int'($urandom_range(0, 1));
            useFast = (s == 1);
            r = 1'($urandom); w = 1'($urandom); a = 8'($urandom); wd = $urandom;
            expD = r ? modelRead(s, w, a) : refDout[s];
            runReq(r, w, a, wd, e, d, m);
            total++;
            if (e != (s == 1 ? 1 : 3) || d !== expD || m !== 1'b0) begin
                bad++;
                $display("[TB] FAIL rand_%0d: dut=%0d rw=%b w=%b a=%h got lat=%0d dout=%h mocAfter=%b, want lat=%0d dout=%h mocAfter=0",
                         i, s, r, w, a, e, d, m, (s == 1 ? 1 : 3), expD);
            end
        end
        useFast = 1'b0;
    endtask

    initial begin
        test_reset;
        initMem;
        test_word_write_read;
        test_byte_write_word_read;
        test_handshake_hold;
        test_early_drop;
        test_mid_reset;
        test_fast_wrap;
        test_random;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL timeout: simulation still running at %0t, want finished", $time);
        $fatal(1, "[TB] timeout");
    end
endmodule
